lap_stopwatch: RTL and testbench
================================

// Module: lap_stopwatch
// PURPOSE
//  Parametrised stopwatch: MM:SS.cc BCD time with debounced start/stop and lap/clear keys.
//  Adds pause/resume, lap-freeze display, lap counting and overflow flagging.
//  Sits between the board key inputs and the 7-seg/display driver; one clock domain.
// PARAMETERS
//  CLK_FREQ_HZ   50_000_000  input clock frequency; tick period = CLK_FREQ_HZ/100 cycles (10 ms)
//  DEBOUNCE_CYC  1_000_000   cycles a key must be stable before a level change is accepted (20 ms @50 MHz)
//  MIN_MAX       99          highest minute value before wrap (BCD, 1..99)
//  LAP_CNT_W     4           width of lap counter
// PORTS
//  clk          in   1          system clock
//  rst_n        in   1          asynchronous active-low reset
//  key_start    in   1          raw key, active low, asynchronous: start/stop toggle
//  key_lap      in   1          raw key, active low, asynchronous: lap (RUN) / clear (PAUSE)
//  centisecond  out  8          BCD 00..99, displayed value
//  second       out  8          BCD 00..59, displayed value
//  minute       out  8          BCD 00..MIN_MAX, displayed value
//  running      out  1          1 while state==RUN
//  lap_hold     out  1          1 while display is frozen on a lap capture
//  lap_count    out  LAP_CNT_W  laps taken since clear, saturating at all-ones
//  overflow     out  1          sticky: time wrapped past MIN_MAX:59.99
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, time 00:00.00, prescaler 0, debouncers at released (1).
//  Keys: 2-FF synchroniser, then debounce counter; accepted level changes only after
//   DEBOUNCE_CYC consecutive stable cycles; one-cycle press pulse on accepted 1->0 only.
//   Holding a key yields exactly one pulse; release generates nothing.
//  Prescaler: counts 0..CLK_FREQ_HZ/100-1 only in RUN; tick pulse on terminal count; held
//   (not cleared) in PAUSE so resume keeps sub-tick phase; cleared on clear/reset.
//  Time counter (live): on tick, cs+1; cs 99->00 carries sec; sec 59->00 carries min;
//   min MIN_MAX->00 sets overflow=1 and keeps running. Pure BCD per digit, no binary convert.
//  States: IDLE, RUN, PAUSE.
//   IDLE  + start -> RUN.      IDLE + lap -> ignored.
//   RUN   + start -> PAUSE, lap_hold<=0 (display shows paused live time).
//   RUN   + lap   -> lap_hold<=1, display regs <= live time (same cycle value incl. a
//                    coincident tick's result), lap_count+1 (saturate); repeat re-captures.
//   PAUSE + start -> RUN.
//   PAUSE + lap   -> clear: live time, display, lap_count, overflow, prescaler <= 0; -> IDLE.
//  Simultaneous start+lap pulses same cycle: start wins, lap dropped.
//  Display outputs = live time when lap_hold==0, else captured lap regs; registered,
//   update 1 cycle after the tick/capture.
//  Latency: key edge -> press pulse = 2 sync + DEBOUNCE_CYC cycles (+-1); pulse -> state 1 cycle.
//  rst_n low mid-count: immediate return to reset values, no pulse generated on release.
// STRUCTURE
//  stopwatch_pkg: state enum {IDLE,RUN,PAUSE}, BCD limit constants (9, 5, MIN_MAX), bcd
//   digit-increment function with carry out.
//  Sub-module key_debounce (sync + counter + press pulse), instantiated twice.
//  Top: prescaler, BCD time chain, FSM, lap capture regs, output mux.
// TESTING (bench overrides CLK_FREQ_HZ=10_000 -> 100 cycles/tick, DEBOUNCE_CYC=16)
//  1 Reset pulse mid-sim -> all outputs 0, state IDLE, no spurious press pulse afterwards.
//  2 start press (bouncy 5 toggles then low 40 cyc) -> exactly one pulse; after 12345 ticks
//    display 02:03.45, running=1.
//  3 RUN, lap at 00:01.20 -> lap_hold=1, display frozen 00:01.20, lap_count=1; live keeps
//    counting; second lap at 00:02.00 -> display 00:02.00, lap_count=2.
//  4 start (pause) at 00:03.00 + 50 cycles, wait 10k cycles, start again -> next cs increment
//    50 cycles after resume; lap in PAUSE -> all zero, lap_count=0, state IDLE.
//  5 Run to 99:59.99 + one tick -> 00:00.00, overflow=1, running=1; clear -> overflow=0.
//  6 start and lap pulses same cycle in RUN -> PAUSE, lap_count unchanged.

Source files
------------

// File: rtl/lap_stopwatch_pkg.sv
// Shared types, BCD limits and digit arithmetic for the lap stopwatch.
package lap_stopwatch_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2
   } state_e;

   // Per-digit terminal values of the MM:SS.cc chain
   localparam logic [3:0] BCD_DIGIT_MAX    = 4'd9;
   localparam logic [3:0] BCD_SEC_TENS_MAX = 4'd5;

   typedef struct packed {
      logic       carry;
      logic [3:0] digit;
   } bcd_inc_t;

   typedef struct packed {
      logic [7:0] minute;
      logic [7:0] second;
      logic [7:0] centi;
   } bcd_time_t;

   // Increment one BCD digit; wraps to 0 with carry once it reaches max
   function automatic bcd_inc_t bcd_digit_inc(input logic [3:0] digit, input logic [3:0] max);
      bcd_inc_t r;
      if (digit >= max) begin
         r.carry = 1'b1;
         r.digit = 4'd0;
      end else begin
         r.carry = 1'b0;
         r.digit = digit + 4'd1;
      end
      return r;
   endfunction

   // Two-digit BCD encoding of a small integer (0..99)
   function automatic logic [7:0] to_bcd2(input int unsigned v);
      return {4'((v / 10) % 10), 4'(v % 10)};
   endfunction

endpackage

// File: rtl/lap_stopwatch_key_debounce.sv
// Raw active-low key: two-flop synchroniser, stability counter, one-cycle press pulse.
module lap_stopwatch_key_debounce #(
   parameter int unsigned DEBOUNCE_CYC = 1_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic key_i,
   output logic press_o
);

   localparam int unsigned    CNT_W    = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

   logic             sync1_q, sync2_q;
   logic             stable_q;
   logic             press_q;
   logic [CNT_W-1:0] cnt_q;

   // Bring the asynchronous key into the clock domain; idles at released (1)
   // NOTE: sequential state is only ever written with <= so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
      end else begin
         sync1_q <= key_i;
         sync2_q <= sync1_q;
      end
   end

   // Accept a level only after DEBOUNCE_CYC consecutive differing samples; pulse on press only
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stable_q <= 1'b1;
         cnt_q    <= '0;
         press_q  <= 1'b0;
      end else begin
         press_q <= 1'b0;
         if (sync2_q == stable_q) begin
            cnt_q <= '0;
         end else if (cnt_q == CNT_LAST) begin
            stable_q <= sync2_q;
            cnt_q    <= '0;
            press_q  <= ~sync2_q;
         end else begin
            cnt_q <= cnt_q + CNT_W'(1);
         end
      end
   end

   assign press_o = press_q;

endmodule

// File: rtl/lap_stopwatch.sv
// MM:SS.cc BCD stopwatch with pause/resume, lap freeze, lap counting and overflow flag.
module lap_stopwatch
   import lap_stopwatch_pkg::*;
#(
   parameter int unsigned CLK_FREQ_HZ  = 50_000_000,
   parameter int unsigned DEBOUNCE_CYC = 1_000_000,
   parameter int unsigned MIN_MAX      = 99,
   parameter int unsigned LAP_CNT_W    = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 key_start,
   input  logic                 key_lap,
   output logic [7:0]           centisecond,
   output logic [7:0]           second,
   output logic [7:0]           minute,
   output logic                 running,
   output logic                 lap_hold,
   output logic [LAP_CNT_W-1:0] lap_count,
   output logic                 overflow
);

   localparam int unsigned      PRE_CNT     = CLK_FREQ_HZ / 100;
   localparam int unsigned      PRE_W       = (PRE_CNT > 1) ? $clog2(PRE_CNT) : 1;
   localparam logic [PRE_W-1:0] PRE_LAST    = PRE_W'(PRE_CNT - 1);
   localparam logic [7:0]       MIN_MAX_BCD = to_bcd2(MIN_MAX);

   logic start_p, lap_p;

   state_e               state_q, state_d;
   logic [PRE_W-1:0]     pre_q, pre_d;
   bcd_time_t            live_q, live_d, live_inc;
   bcd_time_t            disp_q, disp_d;
   logic                 lap_hold_q, lap_hold_d;
   logic [LAP_CNT_W-1:0] lap_cnt_q, lap_cnt_d;
   logic                 ovf_q, ovf_d;
   logic                 tick, wrap, capture;
   bcd_inc_t             c0, c1, s0, s1, m0, m1;

   lap_stopwatch_key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_start_key (
      .clk     (clk),
      .rst_n   (rst_n),
      .key_i   (key_start),
      .press_o (start_p)
   );

   lap_stopwatch_key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_lap_key (
      .clk     (clk),
      .rst_n   (rst_n),
      .key_i   (key_lap),
      .press_o (lap_p)
   );

   assign tick = (state_q == ST_RUN) && (pre_q == PRE_LAST);

   assign c0 = bcd_digit_inc(live_q.centi[3:0],  BCD_DIGIT_MAX);
   assign c1 = bcd_digit_inc(live_q.centi[7:4],  BCD_DIGIT_MAX);
   assign s0 = bcd_digit_inc(live_q.second[3:0], BCD_DIGIT_MAX);
   assign s1 = bcd_digit_inc(live_q.second[7:4], BCD_SEC_TENS_MAX);
   assign m0 = bcd_digit_inc(live_q.minute[3:0], BCD_DIGIT_MAX);
   assign m1 = bcd_digit_inc(live_q.minute[7:4], BCD_DIGIT_MAX);

   // Live time advanced by one centisecond, rippling carries digit by digit
   // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      live_inc = live_q;
      wrap     = 1'b0;
      live_inc.centi[3:0] = c0.digit;
      if (c0.carry) begin
         live_inc.centi[7:4] = c1.digit;
         if (c1.carry) begin
            live_inc.second[3:0] = s0.digit;
            if (s0.carry) begin
               live_inc.second[7:4] = s1.digit;
               if (s1.carry) begin
                  if (live_q.minute == MIN_MAX_BCD) begin
                     live_inc.minute = '0;
                     wrap            = 1'b1;
                  end else begin
                     live_inc.minute[3:0] = m0.digit;
                     if (m0.carry) live_inc.minute[7:4] = m1.digit;
                  end
               end
            end
         end
      end
   end

   // FSM next state, prescaler, lap capture and display selection
   always_comb begin
      state_d    = state_q;
      pre_d      = pre_q;
      live_d     = live_q;
      lap_hold_d = lap_hold_q;
      lap_cnt_d  = lap_cnt_q;
      ovf_d      = ovf_q;
      capture    = 1'b0;

      // Prescaler only moves while running, so a pause keeps the sub-tick phase
      if (state_q == ST_RUN) begin
         pre_d = tick ? '0 : pre_q + PRE_W'(1);
         if (tick) begin
            live_d = live_inc;
            if (wrap) ovf_d = 1'b1;
         end
      end

      // Start has priority: a coincident lap press is dropped
      case (state_q)
         ST_IDLE: begin
            if (start_p) state_d = ST_RUN;
         end
         ST_RUN: begin
            if (start_p) begin
               state_d    = ST_PAUSE;
               lap_hold_d = 1'b0;
            end else if (lap_p) begin
               lap_hold_d = 1'b1;
               capture    = 1'b1;
               if (lap_cnt_q != '1) lap_cnt_d = lap_cnt_q + LAP_CNT_W'(1);
            end
         end
         ST_PAUSE: begin
            if (start_p) begin
               state_d = ST_RUN;
            end else if (lap_p) begin
               state_d    = ST_IDLE;
               live_d     = '0;
               pre_d      = '0;
               lap_cnt_d  = '0;
               ovf_d      = 1'b0;
               lap_hold_d = 1'b0;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // The display register doubles as the lap capture register while frozen
      disp_d = (lap_hold_d && !capture) ? disp_q : live_d;
   end

   // State, time and display registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         pre_q      <= '0;
         live_q     <= '0;
         disp_q     <= '0;
         lap_hold_q <= 1'b0;
         lap_cnt_q  <= '0;
         ovf_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         pre_q      <= pre_d;
         live_q     <= live_d;
         disp_q     <= disp_d;
         lap_hold_q <= lap_hold_d;
         lap_cnt_q  <= lap_cnt_d;
         ovf_q      <= ovf_d;
      end
   end

   assign centisecond = disp_q.centi;
   assign second      = disp_q.second;
   assign minute      = disp_q.minute;
   assign running     = (state_q == ST_RUN);
   assign lap_hold    = lap_hold_q;
   assign lap_count   = lap_cnt_q;
   assign overflow    = ovf_q;

endmodule

// File: tb/tb_lap_stopwatch.sv
// Directed bench: a 100-cycle/tick instance for key/lap/pause timing and a
// 1-cycle/tick, MIN_MAX=2 instance for long counting and minute wrap.
module tb_lap_stopwatch;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic m_start = 1'b1, m_lap = 1'b1, f_start = 1'b1, f_lap = 1'b1;

   logic [7:0] m_cs, m_sec, m_min, f_cs, f_sec, f_min;
   logic       m_run, m_hold, m_ovf, f_run, f_hold, f_ovf;
   logic [3:0] m_laps, f_laps;
   logic [23:0] m_disp, f_disp;

   assign m_disp = {m_min, m_sec, m_cs};
   assign f_disp = {f_min, f_sec, f_cs};

   lap_stopwatch #(.CLK_FREQ_HZ(10_000), .DEBOUNCE_CYC(16), .MIN_MAX(99), .LAP_CNT_W(4)) u_main (
      .clk(clk), .rst_n(rst_n), .key_start(m_start), .key_lap(m_lap),
      .centisecond(m_cs), .second(m_sec), .minute(m_min), .running(m_run),
      .lap_hold(m_hold), .lap_count(m_laps), .overflow(m_ovf)
   );

   lap_stopwatch #(.CLK_FREQ_HZ(100), .DEBOUNCE_CYC(16), .MIN_MAX(2), .LAP_CNT_W(4)) u_fast (
      .clk(clk), .rst_n(rst_n), .key_start(f_start), .key_lap(f_lap),
      .centisecond(f_cs), .second(f_sec), .minute(f_min), .running(f_run),
      .lap_hold(f_hold), .lap_count(f_laps), .overflow(f_ovf)
   );

   always #5 clk = ~clk;

   // Posedge count; at a negedge it equals the index of the edge just taken
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Track running transitions of both instances
   logic m_prev = 1'b0, f_prev = 1'b0;
   int m_rises = 0, m_falls = 0, m_rise_cyc = 0, m_fall_cyc = 0;
   int f_rises = 0, f_falls = 0, f_rise_cyc = 0;
   always @(negedge clk) begin
      if (m_run && !m_prev) begin m_rises++; m_rise_cyc = cyc; end
      if (!m_run && m_prev) begin m_falls++; m_fall_cyc = cyc; end
      if (f_run && !f_prev) begin f_rises++; f_rise_cyc = cyc; end
      m_prev = m_run;
      f_prev = f_run;
   end

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_until(input int target);
      while (cyc < target) @(negedge clk);
   endtask

   task automatic press_m(input logic s, input logic l, input int hold);
      if (s) m_start = 1'b0;
      if (l) m_lap = 1'b0;
      idle(hold);
      m_start = 1'b1;
      m_lap   = 1'b1;
      idle(30);
   endtask

   task automatic press_f(input logic s, input logic l, input int hold);
      if (s) f_start = 1'b0;
      if (l) f_lap = 1'b0;
      idle(hold);
      f_start = 1'b1;
      f_lap   = 1'b1;
      idle(30);
   endtask

   // Hold main start low until running rises (bounded), return the edge index
   task automatic start_m_until_rise(input string name, input int n, output int t);
      int k;
      k = 0;
      m_start = 1'b0;
      while (m_rises < n && k < 200) begin
         @(negedge clk);
         k++;
      end
      check(name, m_rises, n);
      t = (m_rises >= n) ? m_rise_cyc : cyc;
   endtask

   typedef struct {
      logic        key_s;
      logic        key_l;
      int          key_at;
      int          chk_at;
      logic [23:0] disp;
      logic        hold;
      logic [3:0]  laps;
      logic        run;
   } vec_t;

   vec_t vecs[4];

   int m_t0, f_t0, tp, tr, pre_hold, j, rises_before;

   initial begin
      // Lap/pause schedule relative to the run start edge (key-to-state ~20 cycles)
      vecs[0] = '{1'b0, 1'b1, 12030, 12200, 24'h00_01_20, 1'b1, 4'd1, 1'b1};
      vecs[1] = '{1'b0, 1'b0, 15000, 15000, 24'h00_01_20, 1'b1, 4'd1, 1'b1};
      vecs[2] = '{1'b0, 1'b1, 20030, 20200, 24'h00_02_00, 1'b1, 4'd2, 1'b1};
      vecs[3] = '{1'b1, 1'b0, 30030, 30200, 24'h00_03_00, 1'b0, 4'd2, 1'b0};

      // Reset state
      idle(3);
      check("rst_m_disp", m_disp, 24'h0);
      check("rst_m_flags", {m_run, m_hold, m_ovf, m_laps}, 7'h0);
      check("rst_f_flags", {f_disp, f_run, f_hold, f_ovf, f_laps}, 31'h0);
      rst_n = 1'b1;
      idle(5);

      // Bouncy start on the fast instance: five toggles, then held low
      for (int i = 0; i < 5; i++) begin
         f_start = ~f_start;
         idle(3);
      end
      idle(40);
      check("bounce_one_pulse", {f_rises[7:0], f_falls[7:0]}, 16'h0100);
      f_t0 = (f_rises > 0) ? f_rise_cyc : cyc;
      f_start = 1'b1;
      wait_until(f_t0 + 12345);
      check("f_12345_ticks", f_disp, 24'h02_03_45);
      check("f_running", f_run, 1'b1);
      check("f_still_one_pulse", {f_rises[7:0], f_falls[7:0]}, 16'h0100);

      // Minute wrap past MIN_MAX:59.99 sets sticky overflow and keeps running
      wait_until(f_t0 + 17999);
      check("f_before_wrap", {f_disp, f_ovf}, {24'h02_59_99, 1'b0});
      wait_until(f_t0 + 18000);
      check("f_wrap", {f_disp, f_ovf, f_run}, {24'h00_00_00, 1'b1, 1'b1});
      press_f(1'b1, 1'b0, 30);
      check("f_paused", {f_run, f_ovf}, 2'b01);
      press_f(1'b0, 1'b1, 30);
      check("f_clear", {f_disp, f_run, f_ovf, f_laps}, 31'h0);

      // Main instance: start, then table of laps and pause
      start_m_until_rise("m_start", 1, m_t0);
      m_start = 1'b1;
      for (int i = 0; i < 4; i++) begin
         wait_until(m_t0 + vecs[i].key_at);
         if (vecs[i].key_s || vecs[i].key_l) press_m(vecs[i].key_s, vecs[i].key_l, 30);
         wait_until(m_t0 + vecs[i].chk_at);
         check($sformatf("vec%0d_disp", i), m_disp, vecs[i].disp);
         check($sformatf("vec%0d_flags", i), {m_hold, m_laps, m_run},
               {vecs[i].hold, vecs[i].laps, vecs[i].run});
      end

      // Pause holds time and prescaler phase; resume finishes the interrupted tick
      tp       = m_fall_cyc;
      pre_hold = (tp - m_t0) % 100;
      idle(10000);
      check("pause_frozen", {m_disp, m_run}, {24'h00_03_00, 1'b0});
      start_m_until_rise("resume", 2, tr);
      j = 100 - pre_hold;
      wait_until(tr + j - 1);
      check("resume_before_tick", m_disp, 24'h00_03_00);
      wait_until(tr + j);
      check("resume_tick", m_disp, 24'h00_03_01);
      m_start = 1'b1;
      idle(30);

      // Pause then lap clears everything and returns to IDLE; lap in IDLE does nothing
      press_m(1'b1, 1'b0, 30);
      check("pause2", m_run, 1'b0);
      press_m(1'b0, 1'b1, 30);
      check("clear", {m_disp, m_run, m_hold, m_ovf, m_laps}, 31'h0);
      press_m(1'b0, 1'b1, 30);
      check("idle_lap_ignored", {m_disp, m_run, m_hold, m_laps}, 30'h0);

      // Simultaneous start+lap in RUN: pause wins, lap count unchanged
      press_m(1'b1, 1'b0, 30);
      check("run_again", m_run, 1'b1);
      press_m(1'b0, 1'b1, 30);
      check("lap_after_clear", {m_hold, m_laps}, 5'h11);
      press_m(1'b1, 1'b1, 30);
      check("start_wins", {m_run, m_hold, m_laps}, 6'h01);

      // Reset mid-debounce: immediate reset values, no press once released
      rises_before = m_rises;
      m_start = 1'b0;
      idle(8);
      rst_n = 1'b0;
      idle(1);
      check("rst_mid_async", {m_disp, m_run, m_hold, m_ovf, m_laps}, 31'h0);
      m_start = 1'b1;
      idle(4);
      rst_n = 1'b1;
      idle(100);
      check("rst_mid_after", {m_disp, m_run, m_hold, m_ovf, m_laps}, 31'h0);
      check("rst_no_pulse", m_rises, rises_before);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
